fifo_wr_arb: RTL and testbench

Round-robin arbiter that shares the single write port of the dual-clock FIFO between NR producers, such as the Mandelbrot pixel engines, in the write clock domain. Each producer gets a valid/ready stream. The granted producer holds the port for up to BURST accepted beats, then the grant rotates. The block sits between the engines and the FIFO `wr_en`/`in`/`full` pins and is the only writer of that FIFO.

---
 rtl/fifo_wr_arb_pkg.sv | 28 ++
 rtl/fifo_wr_arb_rr_pick.sv | 41 ++++
 rtl/fifo_wr_arb.sv | 143 ++++++++++++++
 tb/tb_fifo_wr_arb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arb_pkg
//  Description : Shared constants and helpers for the FIFO write-side blocks:
//                arbiter state encodings and a constant-evaluable clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_wr_arb_pkg;

    // Arbiter state encodings
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    // Ceiling log2, usable in parameter/localparam expressions; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arb_rr_pick
//  Description : Combinational round-robin picker. Returns the first set bit of
//                the valid vector searching upward (modulo NR) from the
//                pointer, as a one-hot vector, plus an any-valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb_rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int NR = 4,
    parameter int PW = (clog2(NR) < 1) ? 1 : clog2(NR)
) (
    input  logic [NR-1:0] i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [NR-1:0] o_pick,
    output logic          o_any
);

    int   w_idx;
    logic w_found;

    // Walk the requesters starting at the pointer and keep the first valid one
    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NR; k++) begin
            w_idx = (int'(i_ptr) + k) % NR;
            if (!w_found && i_valid[w_idx[PW-1:0]]) begin
                o_pick[w_idx[PW-1:0]] = 1'b1;
                w_found               = 1'b1;
            end
        end
    end

    assign o_any = |i_valid;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arb
//  Description : Round-robin arbiter sharing the single write port of the
//                dual-clock FIFO between NR valid/ready producers. A granted
//                producer keeps the port for up to BURST accepted beats or
//                until it drops valid; every release passes through one idle
//                cycle before the next grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NR    = 4,
    parameter int DW    = 16,
    parameter int BURST = 4
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_clk_en,
    input  logic [NR-1:0]    req_valid,
    input  logic [NR*DW-1:0] req_data,
    output logic [NR-1:0]    req_ready,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [DW-1:0]    fifo_in,
    output logic [NR-1:0]    grant,
    output logic             busy
);

    localparam int c_pw = (clog2(NR) < 1) ? 1 : clog2(NR);
    localparam int c_cw = clog2(BURST) + 1;
    localparam logic [c_cw-1:0] c_burst = c_cw'(BURST);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_pw-1:0] c_last_idx = c_pw'(NR - 1);

    logic [0:0]      r_state;
    logic [NR-1:0]   r_grant;
    logic [c_cw-1:0] r_cnt;
    logic [c_pw-1:0] r_ptr;

    logic [0:0]      w_state_nxt;
    logic [NR-1:0]   w_grant_nxt;
    logic [c_cw-1:0] w_cnt_nxt;
    logic [c_pw-1:0] w_ptr_nxt;

    logic [NR-1:0]   w_pick;
    logic            w_any;
    logic [c_pw-1:0] w_gidx;
    logic [DW-1:0]   w_gdata;
    logic            w_gvalid;
    logic            w_accept;
    logic            w_last_beat;

    fifo_wr_arb_rr_pick #(
        .NR (NR),
        .PW (c_pw)
    ) u_rr_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_any   (w_any)
    );

    // Decode the one-hot grant into an index and mux out that producer's data
    always_comb begin
        w_gidx  = '0;
        w_gdata = '0;
        for (int i = 0; i < NR; i++) begin
            if (r_grant[i]) begin
                w_gidx  = i[c_pw-1:0];
                w_gdata = req_data[i*DW +: DW];
            end
        end
    end

    assign w_gvalid    = |(req_valid & r_grant);
    assign w_accept    = (r_state == c_st_grant) & w_gvalid & ~fifo_full & in_clk_en;
    assign w_last_beat = ((r_cnt + c_cnt_one) == c_burst);

    // State register: everything freezes while the clock enable is low
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= c_st_idle;
            r_grant <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else if (in_clk_en) begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next state: arbitrate in IDLE, count beats and detect release in GRANT
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = '0;
                if (w_any) begin
                    w_state_nxt = c_st_grant;
                    w_grant_nxt = w_pick;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            c_st_grant: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
                // Burst exhausted or producer went away; fifo_full never releases
                if ((w_accept && w_last_beat) || !w_gvalid) begin
                    w_state_nxt = c_st_idle;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = (w_gidx == c_last_idx) ? '0 : (w_gidx + 1'b1);
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Outputs: ready/write gated combinationally by full and clock enable
    always_comb begin
        req_ready  = '0;
        if ((r_state == c_st_grant) && !fifo_full && in_clk_en) begin
            req_ready = r_grant;
        end
        fifo_wr_en = w_accept;
        fifo_in    = w_gdata;
        grant      = r_grant;
        busy       = (r_state == c_st_grant);
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arb
//  Description : Self-checking bench for fifo_wr_arb. Producers emit
//                {index, sequence} words; expected FIFO writes are queued in
//                arbitration order and popped as writes appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

    localparam int NR    = 4;
    localparam int DW    = 16;
    localparam int BURST = 4;

    logic             in_clk;
    logic             in_rst;
    logic             in_clk_en;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_in;
    logic [NR-1:0]    grant;
    logic             busy;

    int            n_checks;
    int            n_errors;
    logic [DW-1:0] sb_q[$];
    int            seq[NR];
    int            lim[NR];
    logic [NR-1:0] en;
    logic [NR-1:0] hs;
    logic          last_wr;
    logic          last_busy;
    logic [NR-1:0] last_ready;
    logic [NR-1:0] last_grant;
    logic [13:0]   pat;
    int            n_wr;

    fifo_wr_arb #(
        .NR    (NR),
        .DW    (DW),
        .BURST (BURST)
    ) dut (
        .in_clk     (in_clk),
        .in_rst     (in_rst),
        .in_clk_en  (in_clk_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_in    (fifo_in),
        .grant      (grant),
        .busy       (busy)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = en[i] && (seq[i] < lim[i]);
            req_data[i*DW +: DW]  = {i[3:0], seq[i][11:0]};
        end
    endtask

    task automatic push(input int p, input int s);
        sb_q.push_back({p[3:0], s[11:0]});
    endtask

    // Sample one cycle at the falling edge, then step past the next rising edge
    task automatic tick();
        logic [DW-1:0] exp;
        @(negedge in_clk);
        last_wr    = fifo_wr_en;
        last_busy  = busy;
        last_ready = req_ready;
        last_grant = grant;
        if (fifo_wr_en) begin
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                check_val("sb_data", 32'(fifo_in), 32'(exp));
            end else begin
                check_val("sb_unexpected_write", 32'(fifo_in), 32'hDEAD_BEEF);
            end
        end
        hs = req_ready & req_valid;
        @(posedge in_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) seq[i]++;
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        en        = '0;
        fifo_full = 1'b0;
        in_clk_en = 1'b1;
        for (int i = 0; i < NR; i++) begin
            seq[i] = 0;
            lim[i] = 1000;
        end
        drive_inputs();
        in_rst = 1'b1;
        repeat (2) @(posedge in_clk);
        #1;
        in_rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        en = '0;
        drive_inputs();
        tick();
        tick();
        check_val(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        in_rst    = 1'b1;
        in_clk_en = 1'b1;
        fifo_full = 1'b0;
        en        = '0;
        for (int i = 0; i < NR; i++) begin
            seq[i] = 0;
            lim[i] = 1000;
        end
        drive_inputs();
        #12;
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        @(posedge in_clk);
        #1;
        in_rst = 1'b0;

        // Single requester: 10 words, 4/idle/4/idle/2 write pattern
        do_reset();
        lim[0] = 10;
        en[0]  = 1'b1;
        drive_inputs();
        for (int s = 0; s < 10; s++) push(0, s);
        pat = 14'b01101111011110;
        for (int c = 0; c < 14; c++) begin
            tick();
            check_val($sformatf("single_wr_c%0d", c), 32'(last_wr), 32'(pat[c]));
        end
        check_val("single_left", 32'(sb_q.size()), 32'd0);

        // Rotation: all requesters busy, 0,1,2,3,0 with one idle bubble
        do_reset();
        en = '1;
        drive_inputs();
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < BURST; b++) push(g % NR, (g / NR) * BURST + b);
        end
        n_wr = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (last_wr) n_wr++;
            if (c % 5 == 1) check_val($sformatf("rot_grant_c%0d", c), 32'(last_grant), 32'(1 << ((c / 5) % NR)));
            if (c % 5 == 0) check_val($sformatf("rot_idle_c%0d", c), 32'(last_busy), 32'd0);
        end
        check_val("rot_writes", 32'(n_wr), 32'd20);
        drain("rot_left");

        // Full stall after beat 2
        do_reset();
        en[0] = 1'b1;
        drive_inputs();
        for (int s = 0; s < 4; s++) push(0, s);
        tick();
        tick();
        check_val("full_b0", 32'(last_wr), 32'd1);
        tick();
        check_val("full_b1", 32'(last_wr), 32'd1);
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("full_wr", 32'(last_wr), 32'd0);
            check_val("full_ready", 32'(last_ready), 32'd0);
            check_val("full_grant", 32'(last_grant), 32'h1);
        end
        fifo_full = 1'b0;
        tick();
        check_val("full_b2", 32'(last_wr), 32'd1);
        tick();
        check_val("full_b3", 32'(last_wr), 32'd1);
        tick();
        check_val("full_release", 32'(last_busy), 32'd0);
        drain("full_left");

        // Early drop: requester 2 leaves after one beat, 3 beats 0 on wrap
        do_reset();
        en     = 4'b1100;
        lim[2] = 1;
        drive_inputs();
        push(2, 0);
        for (int s = 0; s < 4; s++) push(3, s);
        push(0, 0);
        tick();
        en[0] = 1'b1;
        drive_inputs();
        tick();
        check_val("drop_grant2", 32'(last_grant), 32'h4);
        check_val("drop_b0", 32'(last_wr), 32'd1);
        tick();
        check_val("drop_busy", 32'(last_busy), 32'd1);
        check_val("drop_nowr", 32'(last_wr), 32'd0);
        tick();
        check_val("drop_idle", 32'(last_busy), 32'd0);
        tick();
        check_val("drop_grant3", 32'(last_grant), 32'h8);
        repeat (3) tick();
        tick();
        check_val("drop_idle2", 32'(last_busy), 32'd0);
        tick();
        check_val("drop_grant0", 32'(last_grant), 32'h1);
        drain("drop_left");

        // Reset mid-burst: pointer left at 1, must restart at 0
        en     = 4'b0100;
        lim[2] = 1000;
        drive_inputs();
        push(2, seq[2]);
        push(2, seq[2] + 1);
        tick();
        tick();
        check_val("mrst_grant2", 32'(last_grant), 32'h4);
        tick();
        #2;
        in_rst = 1'b1;
        en     = '0;
        drive_inputs();
        #1;
        check_val("mrst_grant", 32'(grant), 32'd0);
        check_val("mrst_busy", 32'(busy), 32'd0);
        check_val("mrst_wr_en", 32'(fifo_wr_en), 32'd0);
        @(negedge in_clk);
        @(negedge in_clk);
        in_rst = 1'b0;
        @(posedge in_clk);
        #1;
        en = 4'b0101;
        drive_inputs();
        push(0, seq[0]);
        tick();
        tick();
        check_val("mrst_restart", 32'(last_grant), 32'h1);
        check_val("mrst_wr", 32'(last_wr), 32'd1);
        drain("mrst_left");

        // Clock enable low for 3 cycles mid-grant
        do_reset();
        en[1] = 1'b1;
        drive_inputs();
        for (int s = 0; s < 4; s++) push(1, s);
        tick();
        tick();
        tick();
        in_clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("ce_wr", 32'(last_wr), 32'd0);
            check_val("ce_ready", 32'(last_ready), 32'd0);
            check_val("ce_grant", 32'(last_grant), 32'h2);
        end
        in_clk_en = 1'b1;
        tick();
        check_val("ce_b2", 32'(last_wr), 32'd1);
        tick();
        check_val("ce_b3", 32'(last_wr), 32'd1);
        tick();
        check_val("ce_release", 32'(last_busy), 32'd0);
        drain("ce_left");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
